// File: rtl/nn_class_argmax_pkg.sv
// Shared constants, types and helpers for the NN classifier argmax stage.
package nn_cls_pkg;

    localparam int N_CLASS      = 4;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 4;
    localparam int IDX_W        = 2;
    localparam int NORMAL_CLASS = 0;

    // Minimum (max - second) distance for a confident decision, unsigned.
    localparam logic [DATA_W-1:0] MARGIN = 16'h0100;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    typedef logic signed [DATA_W-1:0] logit_t;

    // Most negative logit; seeds the runner-up so any real logit beats it.
    localparam logit_t LOGIT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Margin test done one bit wider so extreme logits cannot wrap the difference.
    function automatic logic is_low_conf(input logit_t mx, input logit_t sc);
        logic signed [DATA_W:0] diff;
        diff = {mx[DATA_W-1], mx} - {sc[DATA_W-1], sc};
        return diff < $signed({1'b0, MARGIN});
    endfunction

endpackage

// File: rtl/nn_class_argmax_if.sv
// Control, BRAM port B and result signals of the argmax stage.
interface nn_class_argmax_if;
    import nn_cls_pkg::*;

    logic              en;
    logic              clr;
    logic              ready;
    logic              start;
    logic              done;
    logic              xout_enb;
    logic [ADDR_W-1:0] xout_addrb;
    logic [DATA_W-1:0] xout_doutb;
    logic [IDX_W-1:0]  class_idx;
    logic [DATA_W-1:0] class_max;
    logic [DATA_W-1:0] class_second;
    logic              low_conf;
    logic              attack;

    modport slave (
        input  en, clr, start, xout_doutb,
        output ready, done, xout_enb, xout_addrb,
               class_idx, class_max, class_second, low_conf, attack
    );

    modport master (
        output en, clr, start, xout_doutb,
        input  ready, done, xout_enb, xout_addrb,
               class_idx, class_max, class_second, low_conf, attack
    );

endinterface

// File: rtl/nn_class_argmax_top2_update.sv
// One step of the running top-two search: folds logit v at index i into (max, second, idx).
module nn_top2_update
    import nn_cls_pkg::*;
(
    input  logit_t           cur_max,
    input  logit_t           cur_second,
    input  logic [IDX_W-1:0] cur_idx,
    input  logit_t           v,
    input  logic [IDX_W-1:0] i,
    output logit_t           new_max,
    output logit_t           new_second,
    output logic [IDX_W-1:0] new_idx
);

    // Index 0 restarts the search; strict '>' keeps the lowest index on ties.
    always_comb begin
        new_max    = cur_max;
        new_second = cur_second;
        new_idx    = cur_idx;
        if (i == '0) begin
            new_max    = v;
            new_second = LOGIT_MIN;
            new_idx    = '0;
        end else if (v > cur_max) begin
            new_second = cur_max;
            new_max    = v;
            new_idx    = i;
        end else if (v > cur_second) begin
            new_second = v;
        end
    end

endmodule

// File: rtl/nn_class_argmax.sv
// Argmax / runner-up post-processing of the classifier logits read from the xout BRAM.
module nn_class_argmax
    import nn_cls_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    nn_class_argmax_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_CLASS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_CLASS - 1);
    localparam logic [IDX_W-1:0]  NORMAL_IDX = IDX_W'(NORMAL_CLASS);

    state_t            state;
    logic              enb_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_valid;
    logic [IDX_W-1:0]  rd_idx;
    logic              hold_valid;
    logit_t            hold_data;
    logit_t            rd_data;

    logit_t            run_max;
    logit_t            run_second;
    logic [IDX_W-1:0]  run_idx;
    logit_t            upd_max;
    logit_t            upd_second;
    logic [IDX_W-1:0]  upd_idx;

    logic              ready_q;
    logic              done_q;
    logic [IDX_W-1:0]  res_idx;
    logit_t            res_max;
    logit_t            res_second;
    logic              res_low_conf;
    logic              res_attack;

    // Read data captured during a stall takes precedence over the live BRAM output.
    assign rd_data = hold_valid ? hold_data : bus.xout_doutb;

    nn_top2_update u_update (
        .cur_max    (run_max),
        .cur_second (run_second),
        .cur_idx    (run_idx),
        .v          (rd_data),
        .i          (rd_idx),
        .new_max    (upd_max),
        .new_second (upd_second),
        .new_idx    (upd_idx)
    );

    // Sequencer, read pipeline, running top-two and result registers; en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            state        <= IDLE;
            enb_q        <= 1'b0;
            addr_q       <= '0;
            rd_valid     <= 1'b0;
            rd_idx       <= '0;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            run_max      <= '0;
            run_second   <= '0;
            run_idx      <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            res_idx      <= '0;
            res_max      <= '0;
            res_second   <= '0;
            res_low_conf <= 1'b0;
            res_attack   <= 1'b0;
        end else if (!bus.en) begin
            if (rd_valid && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.xout_doutb;
            end
        end else begin
            hold_valid <= 1'b0;
            rd_valid   <= enb_q;
            rd_idx     <= addr_q[IDX_W-1:0];
            if (rd_valid) begin
                run_max    <= upd_max;
                run_second <= upd_second;
                run_idx    <= upd_idx;
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= FETCH;
                        enb_q   <= 1'b1;
                        addr_q  <= '0;
                        ready_q <= 1'b0;
                    end
                end
                FETCH: begin
                    if (addr_q == LAST_ADDR) begin
                        state <= DRAIN;
                        enb_q <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_valid && rd_idx == LAST_IDX) begin
                        state        <= DONE;
                        done_q       <= 1'b1;
                        res_idx      <= upd_idx;
                        res_max      <= upd_max;
                        res_second   <= upd_second;
                        res_low_conf <= is_low_conf(upd_max, upd_second);
                        res_attack   <= (upd_idx != NORMAL_IDX);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM enable is gated by en so the read port holds its output during a stall.
    assign bus.xout_enb     = enb_q & bus.en;
    assign bus.xout_addrb   = addr_q;
    assign bus.ready        = ready_q;
    assign bus.done         = done_q;
    assign bus.class_idx    = res_idx;
    assign bus.class_max    = res_max;
    assign bus.class_second = res_second;
    assign bus.low_conf     = res_low_conf;
    assign bus.attack       = res_attack;

endmodule
